// File: rtl/axi4_lite_test_memory.sv
// AXI4-Lite slave test memory: word-addressed reads, byte-strobed writes, plus a console
// character sink and a pass/fail mailbox decoded on the write path.
module axi4_lite_test_memory #(
   parameter int unsigned MEM_WORDS    = 32768,
   parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
   parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
   parameter logic [31:0] PASS_VALUE   = 32'd123456789,
   parameter int unsigned VERBOSE      = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_axi_awvalid,
   output logic        mem_axi_awready,
   input  logic [31:0] mem_axi_awaddr,
   input  logic [2:0]  mem_axi_awprot,
   input  logic        mem_axi_wvalid,
   output logic        mem_axi_wready,
   input  logic [31:0] mem_axi_wdata,
   input  logic [3:0]  mem_axi_wstrb,
   output logic        mem_axi_bvalid,
   input  logic        mem_axi_bready,
   input  logic        mem_axi_arvalid,
   output logic        mem_axi_arready,
   input  logic [31:0] mem_axi_araddr,
   input  logic [2:0]  mem_axi_arprot,
   output logic        mem_axi_rvalid,
   input  logic        mem_axi_rready,
   output logic [31:0] mem_axi_rdata,
   output logic        tests_passed
);

   localparam int unsigned IdxW     = $clog2(MEM_WORDS);
   localparam logic [31:0] MemBytes = 32'(MEM_WORDS * 4);

   logic [31:0] memory [MEM_WORDS];

   logic        aw_full_q, aw_full_d;
   logic        w_full_q, w_full_d;
   logic        bvalid_q, bvalid_d;
   logic        rvalid_q, rvalid_d;
   logic        tests_passed_q, tests_passed_d;
   logic [31:0] awaddr_q, awaddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] rdata_q, rdata_d;

   logic            aw_hs, w_hs, ar_hs, commit;
   logic            wr_console, wr_pass, wr_mem, rd_hit;
   logic [IdxW-1:0] wr_idx, rd_idx;
   logic            unused_ok;

   assign aw_hs  = mem_axi_awvalid && !aw_full_q;
   assign w_hs   = mem_axi_wvalid && !w_full_q;
   assign ar_hs  = mem_axi_arvalid && !rvalid_q;
   assign commit = aw_full_q && w_full_q && !bvalid_q;

   // Special addresses take priority over the array, even if the array were large enough to alias.
   assign wr_console = (awaddr_q == CONSOLE_ADDR);
   assign wr_pass    = (awaddr_q == PASS_ADDR);
   assign wr_mem     = (awaddr_q < MemBytes) && !wr_console && !wr_pass;
   assign rd_hit     = (mem_axi_araddr < MemBytes) && (mem_axi_araddr != CONSOLE_ADDR)
                       && (mem_axi_araddr != PASS_ADDR);
   assign wr_idx     = awaddr_q[IdxW+1:2];
   assign rd_idx     = mem_axi_araddr[IdxW+1:2];

   assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot, awaddr_q[1:0], mem_axi_araddr[1:0]};

   always_comb begin
      aw_full_d      = aw_full_q;
      w_full_d       = w_full_q;
      bvalid_d       = bvalid_q;
      rvalid_d       = rvalid_q;
      tests_passed_d = tests_passed_q;
      awaddr_d       = awaddr_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      rdata_d        = rdata_q;

      if (aw_hs) begin
         aw_full_d = 1'b1;
         awaddr_d  = mem_axi_awaddr;
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         wdata_d  = mem_axi_wdata;
         wstrb_d  = mem_axi_wstrb;
      end

      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         if (wr_pass && (wdata_q == PASS_VALUE)) tests_passed_d = 1'b1;
      end else if (bvalid_q && mem_axi_bready) begin
         bvalid_d = 1'b0;
      end

      // Array read samples pre-edge contents, so a same-edge write commit yields old data.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_hit ? memory[rd_idx] : 32'h0;
      end else if (rvalid_q && mem_axi_rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         aw_full_q      <= 1'b0;
         w_full_q       <= 1'b0;
         bvalid_q       <= 1'b0;
         rvalid_q       <= 1'b0;
         tests_passed_q <= 1'b0;
         awaddr_q       <= 32'h0;
         wdata_q        <= 32'h0;
         wstrb_q        <= 4'h0;
         rdata_q        <= 32'h0;
      end else begin
         aw_full_q      <= aw_full_d;
         w_full_q       <= w_full_d;
         bvalid_q       <= bvalid_d;
         rvalid_q       <= rvalid_d;
         tests_passed_q <= tests_passed_d;
         awaddr_q       <= awaddr_d;
         wdata_q        <= wdata_d;
         wstrb_q        <= wstrb_d;
         rdata_q        <= rdata_d;
      end
   end

   // Contents survive reset so a preloaded program is not lost.
   always_ff @(posedge clk) begin
      if (commit && wr_mem) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) memory[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (commit) begin
         if (wr_console) begin
            $write("%c", wdata_q[7:0]);
         end else if (!wr_pass && !wr_mem) begin
            $display("OUT-OF-BOUNDS write addr %08x data %08x", awaddr_q, wdata_q);
         end
         if (VERBOSE != 0) begin
            $display("WR addr %08x data %08x strb %b", awaddr_q, wdata_q, wstrb_q);
         end
      end
      if (ar_hs && (VERBOSE != 0)) begin
         $display("RD addr %08x data %08x", mem_axi_araddr, rd_hit ? memory[rd_idx] : 32'h0);
      end
   end
`endif

   assign mem_axi_awready = !aw_full_q;
   assign mem_axi_wready  = !w_full_q;
   assign mem_axi_bvalid  = bvalid_q;
   assign mem_axi_arready = !rvalid_q;
   assign mem_axi_rvalid  = rvalid_q;
   assign mem_axi_rdata   = rdata_q;
   assign tests_passed    = tests_passed_q;

endmodule

// File: tb/tb_axi4_lite_test_memory.sv
// Directed bench for axi4_lite_test_memory: inputs driven and outputs sampled on the falling edge.
module tb_axi4_lite_test_memory;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid, tests_passed;
   logic [31:0] rdata;
   logic [31:0] rd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi4_lite_test_memory dut (
      .clk             (clk),
      .resetn          (resetn),
      .mem_axi_awvalid (awvalid),
      .mem_axi_awready (awready),
      .mem_axi_awaddr  (awaddr),
      .mem_axi_awprot  (3'b000),
      .mem_axi_wvalid  (wvalid),
      .mem_axi_wready  (wready),
      .mem_axi_wdata   (wdata),
      .mem_axi_wstrb   (wstrb),
      .mem_axi_bvalid  (bvalid),
      .mem_axi_bready  (bready),
      .mem_axi_arvalid (arvalid),
      .mem_axi_arready (arready),
      .mem_axi_araddr  (araddr),
      .mem_axi_arprot  (3'b000),
      .mem_axi_rvalid  (rvalid),
      .mem_axi_rready  (rready),
      .mem_axi_rdata   (rdata),
      .tests_passed    (tests_passed)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present AW and W together, then complete the B handshake.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit aw_done = 0, w_done = 0, got_b = 0;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
         bit aw_hs, w_hs;
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(negedge clk);
         if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
         if (w_hs)  begin wvalid = 1'b0;  w_done = 1; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      for (int n = 0; n < 20 && !got_b; n++) begin
         if (bvalid) got_b = 1;
         else @(negedge clk);
      end
      chk("write_bvalid_seen", {31'b0, got_b}, 32'd1);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
      bit done = 0;
      araddr = a; arvalid = 1'b1; rready = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         if (arready) done = 1;
         @(negedge clk);
      end
      arvalid = 1'b0;
      chk("read_rvalid", {31'b0, rvalid}, 32'd1);
      d = rdata;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_awready", {31'b0, awready}, 32'd1);
      chk("rst_wready", {31'b0, wready}, 32'd1);
      chk("rst_arready", {31'b0, arready}, 32'd1);
      chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_tests_passed", {31'b0, tests_passed}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Preload words 0..3 and read word 2 with rready tied high
      axi_write(32'h0, 32'd11, 4'hf);
      axi_write(32'h4, 32'd22, 4'hf);
      axi_write(32'h8, 32'd33, 4'hf);
      axi_write(32'hC, 32'd44, 4'hf);
      araddr = 32'h8; arvalid = 1'b1; rready = 1'b1;
      chk("rd_arready_before", {31'b0, arready}, 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      chk("rd_rvalid", {31'b0, rvalid}, 32'd1);
      chk("rd_rdata_33", rdata, 32'd33);
      chk("rd_arready_busy", {31'b0, arready}, 32'd0);
      @(negedge clk);
      rready = 1'b0;
      chk("rd_rvalid_cleared", {31'b0, rvalid}, 32'd0);
      chk("rd_arready_again", {31'b0, arready}, 32'd1);

      // W first, AW three cycles later, partial strobes
      axi_write(32'h4, 32'h1122_3344, 4'hf);
      wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      chk("wfirst_wready_low", {31'b0, wready}, 32'd0);
      @(negedge clk);
      chk("wfirst_no_b_1", {31'b0, bvalid}, 32'd0);
      @(negedge clk);
      chk("wfirst_no_b_2", {31'b0, bvalid}, 32'd0);
      awaddr = 32'h4; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      chk("wfirst_no_b_3", {31'b0, bvalid}, 32'd0);
      @(negedge clk);
      chk("wfirst_bvalid", {31'b0, bvalid}, 32'd1);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("wfirst_b_cleared", {31'b0, bvalid}, 32'd0);
      axi_read(32'h4, rd);
      chk("strobe_merge", rd, 32'h11BB_33DD);

      // Mailbox
      axi_write(32'h2000_0000, 32'd123456789, 4'hf);
      chk("pass_set", {31'b0, tests_passed}, 32'd1);
      axi_write(32'h2000_0000, 32'd5, 4'hf);
      chk("pass_sticky", {31'b0, tests_passed}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("pass_reset", {31'b0, tests_passed}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      axi_read(32'h8, rd);
      chk("mem_kept_over_reset", rd, 32'd33);

      // Console and out-of-bounds writes leave the array alone
      axi_write(32'h1000_0000, 32'h0000_0041, 4'hf);
      $display("");
      axi_read(32'h1000_0000, rd);
      chk("console_rdata_zero", rd, 32'd0);
      axi_write(32'h0002_0000, 32'hDEAD_BEEF, 4'hf);
      axi_read(32'h0002_0000, rd);
      chk("oob_rdata_zero", rd, 32'd0);
      axi_read(32'h0, rd);
      chk("oob_no_alias", rd, 32'd11);
      axi_write(32'h0, 32'hFFFF_FFFF, 4'h0);
      axi_read(32'h0, rd);
      chk("strb_zero_no_write", rd, 32'd11);

      // B back-pressure with a second pair queued behind the first response
      awaddr = 32'hC; wdata = 32'h55; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awaddr = 32'h10; wdata = 32'h66;
      begin
         bit taken = 0;
         for (int n = 0; n < 20 && !taken; n++) begin
            if (awready && wready) taken = 1;
            @(negedge clk);
         end
         chk("bp_second_taken", {31'b0, taken}, 32'd1);
      end
      awvalid = 1'b0; wvalid = 1'b0;
      for (int n = 0; n < 5; n++) begin
         chk("bp_bvalid_held", {31'b0, bvalid}, 32'd1);
         chk("bp_awready_low", {31'b0, awready}, 32'd0);
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("bp_b_gap", {31'b0, bvalid}, 32'd0);
      @(negedge clk);
      chk("bp_b_second", {31'b0, bvalid}, 32'd1);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      axi_read(32'hC, rd);
      chk("bp_word_c", rd, 32'h55);
      axi_read(32'h10, rd);
      chk("bp_word_10", rd, 32'h66);

      // Reset while a read is pending and a write pair is latched
      araddr = 32'h0; arvalid = 1'b1; rready = 1'b0;
      awaddr = 32'h0; wdata = 32'hFFFF_FFFF; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      chk("mid_rvalid_before", {31'b0, rvalid}, 32'd1);
      chk("mid_awfull_before", {31'b0, awready}, 32'd0);
      resetn = 1'b0;
      #1;
      chk("mid_rvalid_reset", {31'b0, rvalid}, 32'd0);
      chk("mid_bvalid_reset", {31'b0, bvalid}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("mid_awready", {31'b0, awready}, 32'd1);
      chk("mid_wready", {31'b0, wready}, 32'd1);
      chk("mid_arready", {31'b0, arready}, 32'd1);
      repeat (2) @(negedge clk);
      chk("mid_no_bvalid", {31'b0, bvalid}, 32'd0);
      axi_read(32'h0, rd);
      chk("mid_no_write", rd, 32'd11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
